// File: rtl/mc_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU, the
// unified memory port and the non-architectural registers through each instruction.
module mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   input  logic               negative,
   input  logic               overflow,
   input  logic               carry,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               ir_write,
   output logic               mem_write,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         result_src,
   output logic [1:0]         imm_src,
   output logic [3:0]         alu_control,
   output logic               instr_done,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      EXECI    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10,
      TRAP     = 4'd11
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLL  = 4'b0110,
      ALU_SRL  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_ctl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       taken;
   logic       br_bad;

   // Branch resolution from the flags of the rs1 - rs2 subtraction done this cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      taken  = 1'b0;
      br_bad = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = ~(negative ^ overflow);
         3'b110:  taken = ~carry;
         3'b111:  taken = carry;
         default: br_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_JAL:            state_d = JAL;
               OP_BRANCH:         state_d = BRANCH;
               default:           state_d = TRAP;
            endcase
         end
         MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  if (mem_ready) state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: if (mem_ready) state_d = FETCH;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         JAL:      state_d = ALUWB;
         BRANCH:   state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = TRAP;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment; reset is asynchronous.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   assign state = STATE_W'(state_q);

   // Moore outputs, qualified only by mem_ready and the branch condition.
   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD:  adr_src = 1'b1;
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pc_write   = taken;
            illegal    = br_bad;
            instr_done = 1'b1;
         end
         TRAP:    illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         2'b00: alu_control = ALU_ADD;
         2'b01: alu_control = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE:  imm_src = 2'b01;
         OP_BRANCH: imm_src = 2'b10;
         OP_JAL:    imm_src = 2'b11;
         default:   imm_src = 2'b00;
      endcase
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control FSM for the multicycle RV32I core, the next step after the single-cycle design.
- It sequences one shared ALU, one unified instruction/data memory port and the non-architectural registers (IR, OldPC, A, WriteData, ALUOut, Data) through Fetch/Decode/Execute/Writeback steps.
- It decodes ALU control and immediate format, and resolves all six branch conditions from ALU flags.
- A mem_ready handshake lets memory take more than one cycle.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clk rising edge is the only clock
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero, negative, overflow, carry  in  1 each  ALU flags, current cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut/Result
- ir_write  out  1  IR and OldPC enable
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 (A reg)
- alu_src_b  out  2  00=rs2 (WriteData reg), 01=ImmExt, 10=constant 4
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sltu, 1001 sra
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  high while in TRAP
- state  out  STATE_W  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11.
- Reset: state=FETCH immediately (async). Outputs are a Moore function of state plus the mem_ready and flag qualifiers below, so during reset they show FETCH values with pc_write/ir_write gated by mem_ready. Reset mid-instruction abandons it; no write occurs after reset asserts.
- Unlisted outputs are 0 in every state. alu_control derives from ALUOp: ALUOp 00 → add, 01 → sub.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other op → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits on mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 for every cycle of the wait. Goes to FETCH with instr_done=1 in the mem_ready cycle.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Next is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, pc_write=1. Next is ALUWB (rd=PC+4).
- BRANCH: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, instr_done=1. Next is FETCH.
  - pc_write=taken, where taken by funct3:
  - 000 zero; 001 ~zero
  - 100 negative^overflow; 101 ~(negative^overflow)
  - 110 ~carry; 111 carry
  - 010 and 011 → not taken, and illegal pulses for that cycle.
- TRAP: all enables 0, illegal=1. Held until reset.
- ALUOp=10 decode by funct3:
  - 000 → sub only if op[5]&funct7b5, else add.
  - 010 → slt; 011 → sltu; 100 → xor; 110 → or; 111 → and; 001 → sll.
  - 101 → sra if funct7b5 (R and I alike), else srl.
- imm_src is combinational from op in every state: I/load 00, store 01, branch 10, jal 11; 00 otherwise.
- Cycle counts with mem_ready tied high:
  - lw 5
  - sw, R-type, I-type, jal 4 each
  - branch 3
  - Each memory wait cycle adds 1.

Test Plan:
- Reset asserted at t=3ns mid-cycle → state=0 with no clock edge; after release, FETCH with mem_ready=1 pulses ir_write and pc_write; next state=1.
- op=0000011, mem_ready=1 → states 0,1,2,3,4,0; reg_write only in 4 with result_src=01; instr_done once, in state 4.
- op=0100011, mem_ready low 2 cycles in MEMWRITE → mem_write high 3 consecutive cycles, adr_src=1, reg_write never set, exit on the mem_ready cycle.
- op=0110011, funct3=000, funct7b5=1 → alu_control=0001 in EXECR. op=0010011, funct3=000, funct7b5=1 → 0000. op=0010011, funct3=101, funct7b5=1 → 1001.
- BRANCH sweep: funct3=110 with carry=0 → pc_write=1; funct3=100 with negative=1, overflow=1 → pc_write=0; funct3=001 with zero=0 → 1; each returns to FETCH after 1 cycle.
- op=1111111 → DECODE→TRAP, illegal=1, all enables 0 for 20 cycles; reset then returns to FETCH.
